// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall-bit layout, stop levels,
// default redirect vectors and the controller FSM encoding.
package pipe_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [31:0] EXC_VECTOR_DEF    = 32'h0000_0020;
  localparam logic [31:0] BUSERR_VECTOR_DEF = 32'h0000_0040;
  localparam int          MEM_TIMEOUT_DEF   = 16;

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } ctrlState_e;

  // Holds every stage from PC up to and including lastStage; later stages keep flowing.
  function automatic logic [5:0] stallUpTo(input int lastStage);
    logic [5:0] mask;
    mask = {6{NOSTOP}};
    for (int i = STALL_PC; i <= STALL_WB; i++) begin
      if (i <= lastStage) mask[i] = STOP;
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Memory-stall watchdog: counts consecutive cycles of a held request and
// fires on the last allowed one, so the count never wraps.
module pipe_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic clr_i,
  output logic fire_o
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] wdCnt_q;
  logic [CW-1:0] wdCnt_d;

  assign fire_o = req_i && (wdCnt_q == LAST);

  // Next count: a dropped request or any flush restarts the window.
  always_comb begin
    wdCnt_d = '0;
    if (req_i && !clr_i) wdCnt_d = wdCnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdCnt_q <= '0;
    else        wdCnt_q <= wdCnt_d;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests into the stall
// vector, sequences exception/ERET/bus-error redirects and counts stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
  parameter logic [31:0] BUSERR_VECTOR = BUSERR_VECTOR_DEF,
  parameter int          MEM_TIMEOUT   = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        exc_valid_i,
  input  logic        exc_is_eret_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        timeout_o,
  output logic [31:0] stall_cycles_o
);

  ctrlState_e  state_q;
  logic [31:0] stallCycles_q;
  logic        wdFire;

  pipe_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (stallreq_mem_i),
    .clr_i  (flush_o),
    .fire_o (wdFire)
  );

  // Redirect and stall decode; held at reset values while rst_n is low so a
  // reset in the middle of an event cannot leak a flush or stall.
  always_comb begin
    stall_o   = {6{NOSTOP}};
    flush_o   = 1'b0;
    new_pc_o  = ZeroWord;
    timeout_o = 1'b0;
    if (!rst_n) begin
      stall_o = {6{NOSTOP}};
    end else if (wdFire) begin
      flush_o   = 1'b1;
      new_pc_o  = BUSERR_VECTOR;
      timeout_o = 1'b1;
    end else if (state_q == RUN && exc_valid_i) begin
      flush_o  = 1'b1;
      new_pc_o = exc_is_eret_i ? cp0_epc_i : EXC_VECTOR;
    end else if (stallreq_mem_i) begin
      stall_o = stallUpTo(STALL_MEM);
    end else if (stallreq_ex_i) begin
      stall_o = stallUpTo(STALL_EX);
    end else if (stallreq_id_i) begin
      stall_o = stallUpTo(STALL_ID);
    end
  end

  // Controller FSM: one stale-contents lockout cycle after every flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     state_q <= flush_o ? LOCK : RUN;
        LOCK:    state_q <= flush_o ? LOCK : RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles_q <= ZeroWord;
    end else if (stall_o[STALL_PC] == STOP && stallCycles_q != 32'hFFFF_FFFF) begin
      stallCycles_q <= stallCycles_q + 32'd1;
    end
  end

  assign stall_cycles_o = stallCycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the single-cycle decode
// plus hand-written sequences for lockout, watchdog and reset behaviour.
module tb_pipe_ctrl;

  typedef struct {
    logic        id;
    logic        ex;
    logic        mem;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [5:0]  expStall;
    logic        expFlush;
    logic [31:0] expPc;
    logic        expTimeout;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        exc_valid;
  logic        exc_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;
  logic [31:0] stall_cycles;

  int checks;
  int passes;
  int expCycles;
  vec_t vecs[11];
  vec_t v;

  pipe_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stallreq_id_i  (stallreq_id),
    .stallreq_ex_i  (stallreq_ex),
    .stallreq_mem_i (stallreq_mem),
    .exc_valid_i    (exc_valid),
    .exc_is_eret_i  (exc_is_eret),
    .cp0_epc_i      (cp0_epc),
    .stall_o        (stall),
    .flush_o        (flush),
    .new_pc_o       (new_pc),
    .timeout_o      (timeout),
    .stall_cycles_o (stall_cycles)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic id, input logic ex, input logic mem,
                              input logic exc, input logic eret, input logic [31:0] epc,
                              input logic [5:0] s, input logic f, input logic [31:0] pc,
                              input logic t);
    vec_t r;
    r.id = id; r.ex = ex; r.mem = mem; r.exc = exc; r.eret = eret; r.epc = epc;
    r.expStall = s; r.expFlush = f; r.expPc = pc; r.expTimeout = t;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Drives one vector shortly after a falling edge and lets it settle.
  task automatic applyStimulus(input vec_t s);
    stallreq_id  = s.id;
    stallreq_ex  = s.ex;
    stallreq_mem = s.mem;
    exc_valid    = s.exc;
    exc_is_eret  = s.eret;
    cp0_epc      = s.epc;
    #1;
  endtask

  task automatic checkVector(input string tag, input vec_t s);
    checkOutput({tag, ".stall"},   32'(stall),   32'(s.expStall));
    checkOutput({tag, ".flush"},   32'(flush),   32'(s.expFlush));
    checkOutput({tag, ".new_pc"},  new_pc,       s.expPc);
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(s.expTimeout));
    if (s.expStall[0]) expCycles++;
  endtask

  // Applies a vector for one full clock cycle and checks it mid-cycle.
  task automatic runVector(input string tag, input vec_t s);
    @(negedge clk);
    applyStimulus(s);
    checkVector(tag, s);
  endtask

  initial begin
    checks = 0; passes = 0; expCycles = 0;
    rst_n = 1'b0;
    applyStimulus(mk(0,0,0,0,0,32'h0, 6'h00,0,32'h0,0));

    vecs[0]  = mk(0,0,0,0,0,32'h0,    6'b000000,0,32'h0,   0);
    vecs[1]  = mk(1,0,0,0,0,32'h0,    6'b000111,0,32'h0,   0);
    vecs[2]  = mk(1,0,0,0,0,32'h0,    6'b000111,0,32'h0,   0);
    vecs[3]  = mk(1,0,0,0,0,32'h0,    6'b000111,0,32'h0,   0);
    vecs[4]  = mk(1,1,0,0,0,32'h0,    6'b001111,0,32'h0,   0);
    vecs[5]  = mk(1,1,1,0,0,32'h0,    6'b011111,0,32'h0,   0);
    vecs[6]  = mk(0,1,0,1,0,32'h0,    6'b000000,1,32'h20,  0);
    vecs[7]  = mk(0,1,0,1,0,32'h0,    6'b001111,0,32'h0,   0);
    vecs[8]  = mk(0,0,0,1,1,32'h1234, 6'b000000,1,32'h1234,0);
    vecs[9]  = mk(0,0,0,0,0,32'h1234, 6'b000000,0,32'h0,   0);
    vecs[10] = mk(0,0,0,0,0,32'h0,    6'b000000,0,32'h0,   0);

    #12;
    checkVector("reset", vecs[0]);
    checkOutput("reset.stall_cycles", stall_cycles, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
      if (i == 4) checkOutput("id3.stall_cycles", stall_cycles, 32'd3);
    end
    @(negedge clk);
    checkOutput("table.stall_cycles", stall_cycles, 32'(expCycles));

    // A dropped memory request restarts the watchdog window.
    for (int i = 0; i < 10; i++)
      runVector($sformatf("pre%0d", i), mk(0,0,1,0,0,32'h0, 6'b011111,0,32'h0,0));
    runVector("gap", vecs[0]);
    for (int i = 1; i <= 15; i++)
      runVector($sformatf("wd%0d", i), mk(0,0,1,0,0,32'h0, 6'b011111,0,32'h0,0));
    // Watchdog fire coincides with an ERET: bus-error redirect wins.
    runVector("wdFire", mk(0,0,1,1,1,32'h1234, 6'b000000,1,32'h40,1));
    runVector("wdLock", mk(0,0,1,1,0,32'h0, 6'b011111,0,32'h0,0));
    runVector("wdIdle", vecs[0]);
    @(negedge clk);
    checkOutput("wd.stall_cycles", stall_cycles, 32'(expCycles));

    // Reset asserted while in LOCK with an exception still pending.
    runVector("rstExc", mk(0,0,0,1,0,32'h0, 6'b000000,1,32'h20,0));
    runVector("rstLock", mk(0,0,0,1,0,32'h0, 6'b000000,0,32'h0,0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("inRst.flush", 32'(flush), 32'h0);
    checkOutput("inRst.new_pc", new_pc, 32'h0);
    checkOutput("inRst.stall_cycles", stall_cycles, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postRst.flush", 32'(flush), 32'h1);
    checkOutput("postRst.new_pc", new_pc, 32'h20);
    runVector("end", vecs[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
